// File: rtl/seg_scan_decoder.sv
// Recovers the 4-digit hex message shown on a scanned, active-low 7-segment display.
// Optional macro SEG_SCAN_DP_CAPTURE_EN adds decimal-point capture and comparison.
module seg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        an3,
  input  logic        an2,
  input  logic        an1,
  input  logic        an0,
  input  logic        a,
  input  logic        b,
  input  logic        c,
  input  logic        d,
  input  logic        e,
  input  logic        f,
  input  logic        g,
  input  logic        dp,
  input  logic        err_clr,
  output logic [15:0] msg_out,
  output logic        msg_valid,
  output logic [3:0]  dp_out,
  output logic        err_glyph,
  output logic        err_multi
);

`ifdef SEG_SCAN_DP_CAPTURE_EN
  localparam bit DP_EN = 1'b1;
`else
  localparam bit DP_EN = 1'b0;
`endif
  // With dp capture disabled the dp bit is masked out of every comparison.
  localparam logic [11:0] SAMPLE_MASK = DP_EN ? 12'hFFF : 12'hFFE;
  localparam logic [7:0]  CNT_MAX     = 8'(STABLE_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HELD} state_t;

  function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
    case (seg)
      7'h7E:   return {1'b1, 4'h0};
      7'h30:   return {1'b1, 4'h1};
      7'h6D:   return {1'b1, 4'h2};
      7'h79:   return {1'b1, 4'h3};
      7'h33:   return {1'b1, 4'h4};
      7'h5B:   return {1'b1, 4'h5};
      7'h5F:   return {1'b1, 4'h6};
      7'h70:   return {1'b1, 4'h7};
      7'h7F:   return {1'b1, 4'h8};
      7'h7B:   return {1'b1, 4'h9};
      7'h77:   return {1'b1, 4'hA};
      7'h1F:   return {1'b1, 4'hB};
      7'h4E:   return {1'b1, 4'hC};
      7'h3D:   return {1'b1, 4'hD};
      7'h4F:   return {1'b1, 4'hE};
      7'h47:   return {1'b1, 4'hF};
      default: return 5'b0_0000;
    endcase
  endfunction

  logic [11:0] raw;
  logic [11:0] sync1_q, sync2_q, prev_q;
  logic [11:0] sample, prev_s;
  logic [3:0]  an_low;
  logic [1:0]  an_idx;
  logic        changed, one_low, none_low, multi_low, dp_cap;
  logic [4:0]  glyph;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] slot_q, slot_d;
  logic [3:0]  slot_dp_q, slot_dp_d;
  logic [3:0]  seen_q, seen_d;
  logic        first_q, first_d;
  logic [15:0] msg_q, msg_d;
  logic [3:0]  dp_out_q, dp_out_d;
  logic        valid_q, valid_d;
  logic        err_glyph_q, err_glyph_d;
  logic        err_multi_q, err_multi_d;
  logic        capture, glyph_evt, multi_evt, frame_done;

  assign raw = {an3, an2, an1, an0, a, b, c, d, e, f, g, dp};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
      prev_q  <= '1;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge value,
      // which is what makes this a real two-stage synchronizer.
      sync1_q <= raw;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    an_idx   = 2'd0;
    sample   = sync2_q & SAMPLE_MASK;
    prev_s   = prev_q & SAMPLE_MASK;
    changed  = (sample != prev_s);
    an_low   = ~sample[11:8];
    one_low  = $onehot(an_low);
    none_low = (an_low == 4'h0);
    multi_low = !one_low && !none_low;
    glyph    = decode_glyph(~sample[7:1]);
    dp_cap   = DP_EN & ~sample[0];
    for (int i = 0; i < 4; i++) begin
      if (an_low[i]) an_idx = 2'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture   = 1'b0;
    glyph_evt = 1'b0;
    multi_evt = 1'b0;
    if (multi_low) begin
      multi_evt = 1'b1;
      state_d   = S_IDLE;
      cnt_d     = 8'd0;
    end else if (none_low) begin
      state_d = S_IDLE;
      cnt_d   = 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_SETTLE;
          cnt_d   = 8'd1;
        end
        S_SETTLE: begin
          if (changed) begin
            cnt_d = 8'd1;
          end else begin
            cnt_d = (cnt_q < CNT_MAX) ? cnt_q + 8'd1 : CNT_MAX;
            if (cnt_d == CNT_MAX) begin
              capture   = glyph[4];
              glyph_evt = !glyph[4];
              state_d   = S_HELD;
            end
          end
        end
        S_HELD: begin
          if (changed) begin
            state_d = S_SETTLE;
            cnt_d   = 8'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
        end
      endcase
    end
  end

  // Frame assembly: a full set of seen bits is evaluated one edge after the last capture.
  always_comb begin
    frame_done  = &seen_q;
    slot_d      = slot_q;
    slot_dp_d   = slot_dp_q;
    seen_d      = frame_done ? 4'h0 : seen_q;
    first_d     = first_q;
    msg_d       = msg_q;
    dp_out_d    = dp_out_q;
    valid_d     = 1'b0;
    err_glyph_d = (err_clr ? 1'b0 : err_glyph_q) | glyph_evt;
    err_multi_d = (err_clr ? 1'b0 : err_multi_q) | multi_evt;
    if (capture) begin
      slot_d[{an_idx, 2'b00} +: 4] = glyph[3:0];
      slot_dp_d[an_idx]            = dp_cap;
      seen_d[an_idx]               = 1'b1;
    end
    if (frame_done && (first_q || slot_q != msg_q || slot_dp_q != dp_out_q)) begin
      valid_d  = 1'b1;
      msg_d    = slot_q;
      dp_out_d = slot_dp_q;
      first_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      // NOTE: the slot registers are few and small, so they are reset with the rest
      // of the state; a partial frame can never leak across a reset.
      slot_q      <= 16'h0000;
      slot_dp_q   <= 4'h0;
      seen_q      <= 4'h0;
      first_q     <= 1'b1;
      msg_q       <= 16'h0000;
      dp_out_q    <= 4'h0;
      valid_q     <= 1'b0;
      err_glyph_q <= 1'b0;
      err_multi_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      slot_q      <= slot_d;
      slot_dp_q   <= slot_dp_d;
      seen_q      <= seen_d;
      first_q     <= first_d;
      msg_q       <= msg_d;
      dp_out_q    <= dp_out_d;
      valid_q     <= valid_d;
      err_glyph_q <= err_glyph_d;
      err_multi_q <= err_multi_d;
    end
  end

  assign msg_out   = msg_q;
  assign msg_valid = valid_q;
  assign dp_out    = dp_out_q;
  assign err_glyph = err_glyph_q;
  assign err_multi = err_multi_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: directed scenarios plus randomized scans
// compared every cycle against a run-length reference model.
module tb_seg_scan_decoder;
  localparam int S = 8;
`ifdef SEG_SCAN_DP_CAPTURE_EN
  localparam bit DP_EN = 1'b1;
`else
  localparam bit DP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  an_n = 4'hF;
  logic [6:0]  seg_n = 7'h7F;
  logic        dp_n = 1'b1;
  logic        err_clr = 1'b0;
  logic [15:0] msg_out;
  logic        msg_valid;
  logic [3:0]  dp_out;
  logic        err_glyph, err_multi;

  int checks = 0;
  int errors = 0;
  int obs_pulses = 0;

  always #5 clk = ~clk;

  seg_scan_decoder #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset),
    .an3(an_n[3]), .an2(an_n[2]), .an1(an_n[1]), .an0(an_n[0]),
    .a(seg_n[6]), .b(seg_n[5]), .c(seg_n[4]), .d(seg_n[3]),
    .e(seg_n[2]), .f(seg_n[1]), .g(seg_n[0]), .dp(dp_n),
    .err_clr(err_clr), .msg_out(msg_out), .msg_valid(msg_valid),
    .dp_out(dp_out), .err_glyph(err_glyph), .err_multi(err_multi)
  );

  // Active-high glyph table, a as MSB, indexed by hex digit.
  logic [6:0] gtab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                            7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  // Reference model state.
  logic [11:0] hq[$];
  logic [15:0] m_frame, m_msg;
  logic [3:0]  m_fdp, m_dp, m_seen;
  logic        m_valid, m_eg, m_em, m_first, m_done;
  int          m_run, m_pulses;

  task automatic model_reset();
    hq = '{12'hFFF, 12'hFFF, 12'hFFF};
    m_frame = 16'h0; m_msg = 16'h0; m_fdp = 4'h0; m_dp = 4'h0; m_seen = 4'h0;
    m_valid = 1'b0; m_eg = 1'b0; m_em = 1'b0; m_first = 1'b1; m_done = 1'b0;
    m_run = 0;
  endtask

  task automatic model_step();
    logic [11:0] s, ps, mask;
    logic [6:0]  seg;
    int nlow, idx, dig;
    if (!reset) begin
      model_reset();
      return;
    end
    mask = DP_EN ? 12'hFFF : 12'hFFE;
    s  = hq[1] & mask;
    ps = hq[2] & mask;
    m_valid = 1'b0;
    if (m_seen == 4'hF) begin
      if (m_first || m_frame != m_msg || m_fdp != m_dp) begin
        m_valid = 1'b1; m_msg = m_frame; m_dp = m_fdp; m_first = 1'b0;
        m_pulses++;
      end
      m_seen = 4'h0;
    end
    if (err_clr) begin
      m_eg = 1'b0; m_em = 1'b0;
    end
    nlow = 0; idx = 0;
    for (int i = 0; i < 4; i++) if (!s[8+i]) begin nlow++; idx = i; end
    if (nlow >= 2) begin
      m_em = 1'b1; m_run = 0;
    end else if (nlow == 0) begin
      m_run = 0;
    end else begin
      if (m_run == 0 || s != ps) begin m_run = 1; m_done = 1'b0; end
      else if (m_run < S) m_run++;
      if (!m_done && m_run == S) begin
        m_done = 1'b1;
        seg = ~s[7:1];
        dig = -1;
        for (int k = 0; k < 16; k++) if (gtab[k] == seg) dig = k;
        if (dig < 0) m_eg = 1'b1;
        else begin
          m_frame[idx*4 +: 4] = 4'(dig);
          m_fdp[idx] = DP_EN & ~s[0];
          m_seen[idx] = 1'b1;
        end
      end
    end
    hq.push_front({an_n, seg_n, dp_n});
    void'(hq.pop_back());
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    if (msg_valid === 1'b1) obs_pulses++;
    check("msg_out", 32'(msg_out), 32'(m_msg));
    check("dp_out", 32'(dp_out), 32'(m_dp));
    check("msg_valid", 32'(msg_valid), 32'(m_valid));
    check("err_glyph", 32'(err_glyph), 32'(m_eg));
    check("err_multi", 32'(err_multi), 32'(m_em));
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic blank(input int n);
    an_n = 4'hF; seg_n = 7'h7F; dp_n = 1'b1;
    run(n);
  endtask

  task automatic slot(input int an, input logic [6:0] seg_ah, input bit dpv, input int len);
    an_n = ~(4'b0001 << an); seg_n = ~seg_ah; dp_n = ~dpv;
    run(len);
  endtask

  task automatic frame(input logic [15:0] v, input int len);
    for (int i = 3; i >= 0; i--) slot(i, gtab[v[i*4 +: 4]], 1'b0, len);
  endtask

  int p0;
  int an, len, r;
  logic [6:0] segs;

  initial begin
    model_reset();
    m_pulses = 0;
    run(3);
    check("rst_msg_out", 32'(msg_out), 32'h0);
    check("rst_dp_out", 32'(dp_out), 32'h0);
    check("rst_msg_valid", 32'(msg_valid), 32'h0);
    check("rst_errs", 32'({err_glyph, err_multi}), 32'h0);
    reset = 1'b1;
    blank(4);

    // Basic "1234" scan with 20-cycle slots.
    p0 = obs_pulses;
    frame(16'h1234, 20);
    blank(4);
    check("t1_pulses", 32'(obs_pulses - p0), 32'd1);
    check("t1_msg", 32'(msg_out), 32'h1234);

    // Repeated identical frames are silent; a changed frame pulses once.
    p0 = obs_pulses;
    repeat (3) frame(16'h1234, 20);
    check("t2_repeat_pulses", 32'(obs_pulses - p0), 32'd0);
    frame(16'h12C4, 20);
    blank(4);
    check("t2_change_pulses", 32'(obs_pulses - p0), 32'd1);
    check("t2_msg", 32'(msg_out), 32'h12C4);

    // Too-short an1 slot: no capture, no completed frame.
    p0 = obs_pulses;
    slot(3, gtab[5], 1'b0, 20);
    slot(2, gtab[6], 1'b0, 20);
    slot(1, gtab[7], 1'b0, 5);
    slot(0, gtab[8], 1'b0, 20);
    blank(6);
    check("t3_short_pulses", 32'(obs_pulses - p0), 32'd0);
    check("t3_short_msg", 32'(msg_out), 32'h12C4);
    slot(1, gtab[7], 1'b0, 20);
    blank(4);
    check("t3_fill_msg", 32'(msg_out), 32'h5678);

    // Invalid glyph, sticky flag, and err_clr coinciding with a new error.
    slot(2, 7'h01, 1'b0, 20);
    blank(10);
    check("t4_glyph_set", 32'(err_glyph), 32'd1);
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    check("t4_glyph_clr", 32'(err_glyph), 32'd0);
    blank(4);
    an_n = 4'b1011; seg_n = ~7'h01; dp_n = 1'b1;
    run(S + 1);
    check("t4_glyph_pre", 32'(err_glyph), 32'd0);
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    check("t4_glyph_coincide", 32'(err_glyph), 32'd1);
    blank(4);

    // Two anodes low for a single cycle.
    an_n = 4'b0110; seg_n = ~gtab[3];
    cycle();
    blank(4);
    check("t5_multi", 32'(err_multi), 32'd1);

    // Reset during the an1 slot, then a frame equal to the reset value of msg_out.
    slot(3, gtab[9], 1'b0, 20);
    slot(2, gtab[9], 1'b0, 20);
    slot(1, gtab[9], 1'b0, 10);
    reset = 1'b0;
    run(2);
    check("t6_rst_msg", 32'(msg_out), 32'h0);
    check("t6_rst_flags", 32'({msg_valid, err_glyph, err_multi, dp_out}), 32'h0);
    reset = 1'b1;
    p0 = obs_pulses;
    frame(16'h0000, 20);
    blank(4);
    check("t6_first_pulse", 32'(obs_pulses - p0), 32'd1);
    check("t6_first_msg", 32'(msg_out), 32'h0000);

    // Decimal point lit on an2 only.
    for (int i = 3; i >= 0; i--) slot(i, gtab[10 + i], i == 2, 20);
    blank(4);
    check("t7_dp", 32'(dp_out), DP_EN ? 32'h4 : 32'h0);
    check("t7_msg", 32'(msg_out), 32'hDCBA);

    // Randomized scans with glitches, bad glyphs, dp toggles and err_clr pulses.
    for (int fr = 0; fr < 40; fr++) begin
      for (int k = 0; k < 4; k++) begin
        an   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : 3 - k;
        segs = ($urandom_range(0, 9) == 0) ? 7'($urandom) : gtab[$urandom_range(0, 15)];
        len  = int'($urandom_range(4, 22));
        err_clr = ($urandom_range(0, 15) == 0);
        an_n = ~(4'b0001 << an); seg_n = ~segs; dp_n = 1'($urandom);
        cycle();
        err_clr = 1'b0;
        run(len / 2);
        if ($urandom_range(0, 2) == 0) dp_n = ~dp_n;
        run(len - len / 2);
        r = int'($urandom_range(0, 19));
        if (r == 0) blank(int'($urandom_range(1, 5)));
        else if (r == 1) begin
          an_n = 4'($urandom);
          run(int'($urandom_range(1, 3)));
        end
      end
    end
    blank(6);
    check("pulse_total", 32'(obs_pulses), 32'(m_pulses));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
